// File: rtl/systolic_sequencer_pkg.sv
// Shared definitions for the systolic sequencer, controller, memory and array.
package systolic_pkg;

    localparam int PE_NUMBER_DEFAULT = 64;
    localparam int ADDR_SIZE_DEFAULT = 16;
    localparam int LEN_W_DEFAULT     = 16;
    localparam logic [15:0] ZERO_POINT_ADDR_DEFAULT = 16'h5555;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_W,
        STREAM,
        FLUSH,
        WB,
        DONE
    } seq_state_t;

endpackage

// File: rtl/systolic_sequencer_phase_counter.sv
// Loadable down-counter with terminal-count flag; one instance per sequencer phase.
module phase_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one matrix-vector job: clear, weight load, padded vector stream, writeback.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int PE_NUMBER = PE_NUMBER_DEFAULT,
    parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT,
    parameter int LEN_W     = LEN_W_DEFAULT,
    parameter logic [ADDR_SIZE-1:0] ZERO_POINT_ADDR = ADDR_SIZE'(ZERO_POINT_ADDR_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [ADDR_SIZE-1:0]         mat_base,
    input  logic [ADDR_SIZE-1:0]         vec_base,
    input  logic [ADDR_SIZE-1:0]         out_base,
    input  logic [LEN_W-1:0]             vec_len,
    output logic                         busy,
    output logic                         done,
    output logic                         err_busy,
    output logic [ADDR_SIZE-1:0]         r_addr,
    output logic                         r_en,
    output logic                         arr_clr,
    output logic                         arr_load_w,
    output logic                         arr_shift,
    output logic [$clog2(PE_NUMBER)-1:0] l_d_o_addr,
    output logic [ADDR_SIZE-1:0]         w_addr,
    output logic                         w_en
);

    localparam int PW = $clog2(PE_NUMBER);
    // Wide enough for vec_len+PE_NUMBER-1 at the largest vec_len.
    localparam int CW = ((LEN_W > PW) ? LEN_W : PW) + 1;

    seq_state_t state, state_nxt;

    logic [ADDR_SIZE-1:0] mat_q, vec_q, out_q;
    logic [LEN_W-1:0]     len_q;
    logic                 load_w_q, shift_q;

    logic [CW-1:0] cnt_i, cnt_k, cnt_j;
    logic          tc_i, tc_k, tc_j;
    logic [CW-1:0] pe_last, k_last;
    logic [CW-1:0] idx_i, idx_k, idx_j;

    assign pe_last = CW'(PE_NUMBER - 1);
    assign k_last  = CW'(len_q) + CW'(PE_NUMBER) - CW'(2);

    // Counters run down; the phase index is the distance from the loaded value.
    assign idx_i = pe_last - cnt_i;
    assign idx_k = k_last - cnt_k;
    assign idx_j = pe_last - cnt_j;

    phase_counter #(.W(CW)) u_cnt_i (
        .clk(clk), .reset(reset),
        .load(state == CLEAR), .load_val(pe_last),
        .en(state == LOAD_W), .count(cnt_i), .tc(tc_i)
    );

    phase_counter #(.W(CW)) u_cnt_k (
        .clk(clk), .reset(reset),
        .load((state == LOAD_W) && tc_i), .load_val(k_last),
        .en(state == STREAM), .count(cnt_k), .tc(tc_k)
    );

    phase_counter #(.W(CW)) u_cnt_j (
        .clk(clk), .reset(reset),
        .load(state == FLUSH), .load_val(pe_last),
        .en(state == WB), .count(cnt_j), .tc(tc_j)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mat_q    <= '0;
            vec_q    <= '0;
            out_q    <= '0;
            len_q    <= '0;
            load_w_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            load_w_q <= (state == LOAD_W) && !abort;
            shift_q  <= (state == STREAM) && !abort;
            if ((state == IDLE) && start) begin
                mat_q <= mat_base;
                vec_q <= vec_base;
                out_q <= out_base;
                len_q <= vec_len;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        err_busy   = start && (state != IDLE);
        r_addr     = '0;
        r_en       = 1'b0;
        arr_clr    = 1'b0;
        l_d_o_addr = '0;
        w_addr     = '0;
        w_en       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (vec_len == '0) ? DONE : CLEAR;
            end
            CLEAR: begin
                arr_clr   = 1'b1;
                state_nxt = LOAD_W;
            end
            LOAD_W: begin
                r_en   = 1'b1;
                r_addr = mat_q + ADDR_SIZE'(idx_i);
                if (tc_i) state_nxt = STREAM;
            end
            STREAM: begin
                r_en   = 1'b1;
                r_addr = (idx_k < CW'(len_q)) ? (vec_q + ADDR_SIZE'(idx_k)) : ZERO_POINT_ADDR;
                if (tc_k) state_nxt = FLUSH;
            end
            FLUSH: begin
                state_nxt = WB;
            end
            WB: begin
                l_d_o_addr = PW'(idx_j);
                w_addr     = out_q + ADDR_SIZE'(idx_j);
                w_en       = 1'b1;
                if (tc_j) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) state_nxt = IDLE;
    end

    assign arr_load_w = load_w_q;
    assign arr_shift  = shift_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench: per-cycle expected output vectors derived from the job timeline.
module tb_systolic_sequencer;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] mat_base = '0, vec_base = '0, out_base = '0, vec_len = '0;
    logic        busy, done, err_busy, r_en, arr_clr, arr_load_w, arr_shift, w_en;
    logic [15:0] r_addr, w_addr;
    logic [1:0]  l_d_o_addr;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err_busy;
        logic        r_en;
        logic        arr_clr;
        logic        arr_load_w;
        logic        arr_shift;
        logic        w_en;
        logic [1:0]  lsel;
        logic [15:0] r_addr;
        logic [15:0] w_addr;
    } obs_t;

    obs_t sb[$];
    int   total = 0;
    int   bad = 0;

    systolic_sequencer #(.PE_NUMBER(P), .ADDR_SIZE(16), .LEN_W(16), .ZERO_POINT_ADDR(16'h5555)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mat_base(mat_base), .vec_base(vec_base), .out_base(out_base), .vec_len(vec_len),
        .busy(busy), .done(done), .err_busy(err_busy),
        .r_addr(r_addr), .r_en(r_en), .arr_clr(arr_clr),
        .arr_load_w(arr_load_w), .arr_shift(arr_shift),
        .l_d_o_addr(l_d_o_addr), .w_addr(w_addr), .w_en(w_en)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.busy = busy; o.done = done; o.err_busy = err_busy; o.r_en = r_en;
        o.arr_clr = arr_clr; o.arr_load_w = arr_load_w; o.arr_shift = arr_shift;
        o.w_en = w_en; o.lsel = l_d_o_addr; o.r_addr = r_addr; o.w_addr = w_addr;
        return o;
    endfunction

    // Expected outputs at cycle c of a job whose start is driven at cycle 0.
    function automatic obs_t model(input int c, input int n, input logic [15:0] mat,
                                   input logic [15:0] vec, input logic [15:0] outb,
                                   input int errc, input int abortc);
        obs_t e;
        int s0, fl, w0, dn, k;
        e = '0;
        if (abortc >= 1 && c > abortc) return e;
        if (n == 0) begin
            if (c == 1) begin e.busy = 1'b1; e.done = 1'b1; end
            e.err_busy = (c == errc) && e.busy;
            return e;
        end
        s0 = P + 2;
        fl = s0 + n + P - 1;
        w0 = fl + 1;
        dn = w0 + P;
        e.busy = (c >= 1) && (c <= dn);
        e.arr_clr = (c == 1);
        if (c >= 2 && c <= P + 1) begin
            e.r_en = 1'b1;
            e.r_addr = mat + 16'(c - 2);
        end
        e.arr_load_w = (c >= 3) && (c <= P + 2);
        if (c >= s0 && c < fl) begin
            k = c - s0;
            e.r_en = 1'b1;
            e.r_addr = (k < n) ? vec + 16'(k) : 16'h5555;
        end
        e.arr_shift = (c > s0) && (c <= fl);
        if (c >= w0 && c < dn) begin
            e.w_en = 1'b1;
            e.lsel = 2'(c - w0);
            e.w_addr = outb + 16'(c - w0);
        end
        e.done = (c == dn);
        e.err_busy = (c == errc) && e.busy;
        return e;
    endfunction

    task automatic run_job(input string name, input int n, input logic [15:0] mat,
                           input logic [15:0] vec, input logic [15:0] outb,
                           input int errc, input int abortc, input int rstc);
        int   last;
        obs_t exp_v, act;
        if (abortc >= 1) last = abortc + 1;
        else if (n == 0) last = 2;
        else last = 3 * P + n + 2;
        if (rstc >= 0) last = rstc - 1;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (c == errc);
            abort = (c == abortc);
            if (c == 0) begin
                mat_base = mat; vec_base = vec; out_base = outb; vec_len = 16'(n);
            end
            sb.push_back(model(c, n, mat, vec, outb, errc, abortc));
            @(negedge clk);
            act = sample();
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL %s cycle %0d: scoreboard empty", name, c);
            end else begin
                exp_v = sb.pop_front();
                if (act !== exp_v) begin
                    bad++;
                    $display("FAIL %s cycle %0d: got %h required %h", name, c, act, exp_v);
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (rstc >= 0) begin
            @(posedge clk);
            #2 reset = 1'b0;
            #1;
            act = sample();
            total++;
            if (act !== obs_t'('0)) begin
                bad++;
                $display("FAIL %s async reset: got %h required 0", name, act);
            end
            repeat (2) @(posedge clk);
            #1 reset = 1'b1;
        end
    endtask

    task automatic test_reset();
        obs_t act;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        act = sample();
        total++;
        if (act !== obs_t'('0)) begin
            bad++;
            $display("FAIL reset_state: got %h required 0", act);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_basic();
        run_job("basic", 3, 16'h0100, 16'h0200, 16'h0300, -1, -1, -1);
    endtask

    task automatic test_zero_len();
        run_job("zero_len", 0, 16'h0100, 16'h0200, 16'h0300, -1, -1, -1);
    endtask

    task automatic test_wrap();
        run_job("wrap", 3, 16'hFFFD, 16'hFFFE, 16'hFFFE, -1, -1, -1);
    endtask

    task automatic test_err_busy();
        run_job("err_busy", 3, 16'h0100, 16'h0200, 16'h0300, 7, -1, -1);
    endtask

    task automatic test_abort();
        run_job("abort", 3, 16'h0100, 16'h0200, 16'h0300, -1, 8, -1);
        run_job("after_abort", 3, 16'h0100, 16'h0200, 16'h0300, -1, -1, -1);
    endtask

    task automatic test_start_abort_same_cycle();
        run_job("start_abort", 2, 16'h0A00, 16'h0B00, 16'h0C00, -1, 0, -1);
    endtask

    task automatic test_async_reset();
        run_job("async_reset", 3, 16'h0100, 16'h0200, 16'h0300, -1, -1, 10);
        run_job("after_reset", 5, 16'h1000, 16'h2000, 16'h3000, -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_job("b2b_a", 1, 16'h0040, 16'h0050, 16'h0060, -1, -1, -1);
        run_job("b2b_b", 6, 16'h7000, 16'h8000, 16'h9000, 12, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_err_busy();
        test_abort();
        test_start_abort_same_cycle();
        test_async_reset();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
